// File: rtl/updown_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// updown_ramp_ctrl
//
// Round-robin sequencer sharing one 4-bit up/down counter between two
// requesters. A granted requester gets its start value loaded into the
// counter. The counter then steps one count per cycle toward the stop value,
// and a one-cycle done pulse is returned to that requester at the end.
//
// Build option:
//   UPDOWN_RAMP_TRIANGLE_EN  - when defined, the counter ramps back from the
//                              stop value to the start value before finishing
//                              (triangle). When undefined, done follows the
//                              first ramp directly.
//
// Ports:
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   req[1:0]          per-requester request, held high until its done
//   start0 / stop0    ramp endpoints for requester 0
//   start1 / stop1    ramp endpoints for requester 1
//   gnt[1:0]          registered one-hot grant
//   done[1:0]         one-cycle completion pulse to the granted requester
//   busy              high in every state except IDLE
//   count[3:0]        counter value
//   dir               registered step direction (0 = up, 1 = down)
// -----------------------------------------------------------------------------
module updown_ramp_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] start0,
  input  logic [3:0] stop0,
  input  logic [3:0] start1,
  input  logic [3:0] stop1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic [3:0] count,
  output logic       dir
);

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_RETURN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              last;       // requester granted most recently
  logic [DATA_W-1:0] op_start;   // endpoints latched at grant time
  logic [DATA_W-1:0] op_stop;

  logic              any_req;
  logic              win;        // index of the requester that wins arbitration
  logic [DATA_W-1:0] sel_start;
  logic [DATA_W-1:0] sel_stop;
  logic              req_g;      // request line of the current grantee
  logic [DATA_W-1:0] count_step;

  // One count toward the target. The FSM never steps past an in-range
  // target, so the clamp at the rails is only a guard against wrap-around.
  function automatic logic [DATA_W-1:0] step_sat(input logic [DATA_W-1:0] v,
                                                 input logic              down);
    logic [DATA_W-1:0] r;
    if (down) begin
      r = (v == '0) ? v : v - 1'b1;
    end else begin
      r = (v == '1) ? v : v + 1'b1;
    end
    return r;
  endfunction

  // Arbitration: a tie goes to the requester that was not served last.
  always_comb begin
    any_req = |req;
    if (req == 2'b11) begin
      win = ~last;
    end else begin
      win = req[1];
    end
    sel_start = win ? start1 : start0;
    sel_stop  = win ? stop1  : stop0;
  end

  assign req_g      = |(req & gnt);
  assign count_step = step_sat(count, dir);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dropped request aborts any active state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req_g) begin
          state_nxt = S_IDLE;
        end else if (op_start == op_stop) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!req_g) begin
          state_nxt = S_IDLE;
        end else if (count_step == op_stop) begin
`ifdef UPDOWN_RAMP_TRIANGLE_EN
          state_nxt = S_RETURN;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef UPDOWN_RAMP_TRIANGLE_EN
      S_RETURN: begin
        if (!req_g) begin
          state_nxt = S_IDLE;
        end else if (count_step == op_start) begin
          state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant, direction, counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt   <= 2'b00;
      dir   <= 1'b0;
      count <= '0;
      last  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt  <= win ? 2'b10 : 2'b01;
            dir  <= (sel_stop < sel_start);
            last <= win;
          end
        end
        S_LOAD: begin
          if (req_g) begin
            count <= op_start;
          end else begin
            gnt <= 2'b00;
          end
        end
        S_RUN: begin
          if (req_g) begin
            count <= count_step;
`ifdef UPDOWN_RAMP_TRIANGLE_EN
            // Turn around on the edge that lands on the stop value.
            if (count_step == op_stop) begin
              dir <= ~dir;
            end
`endif
          end else begin
            gnt <= 2'b00;
          end
        end
`ifdef UPDOWN_RAMP_TRIANGLE_EN
        S_RETURN: begin
          if (req_g) begin
            count <= count_step;
          end else begin
            gnt <= 2'b00;
          end
        end
`endif
        S_DONE: begin
          gnt <= 2'b00;
        end
        default: begin
          gnt <= 2'b00;
        end
      endcase
    end
  end

  // Ramp endpoints are captured only at grant; later input changes are ignored.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && any_req) begin
      op_start <= sel_start;
      op_stop  <= sel_stop;
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE) ? gnt : 2'b00;
  end

endmodule

// File: tb/tb_updown_ramp_ctrl.sv
module tb_updown_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] start0, stop0, start1, stop1;
  logic [1:0] gnt, done;
  logic       busy;
  logic [3:0] count;
  logic       dir;

  int total = 0;
  int bad   = 0;

  updown_ramp_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .start0(start0),
    .stop0 (stop0),
    .start1(start1),
    .stop1 (stop1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count),
    .dir   (dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] s0, e0, s1, e1;
    logic [1:0] gnt, done;
    logic       busy;
    logic [3:0] count;
    logic       dir;
  } vec_t;

  vec_t tbl [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called in an IDLE cycle with req already driven so requester g wins.
  // Follows the whole operation and ends in the IDLE cycle after DONE.
  task automatic ramp(input int g, input int s, input int e, input string nm);
    int n;
    int c;
    int stp;
    int oh;
    oh  = (g == 1) ? 2 : 1;
    n   = (e > s) ? (e - s) : (s - e);
    stp = (e > s) ? 1 : -1;
    tick;
    check($sformatf("%s load gnt", nm), int'(gnt), oh);
    check($sformatf("%s load busy", nm), int'(busy), 1);
    check($sformatf("%s load dir", nm), int'(dir), (e < s) ? 1 : 0);
    check($sformatf("%s load done", nm), int'(done), 0);
    tick;
    c = s;
    check($sformatf("%s first count", nm), int'(count), c);
    check($sformatf("%s first done", nm), int'(done), (n == 0) ? oh : 0);
    for (int k = 1; k <= n; k++) begin
      tick;
      c = c + stp;
      check($sformatf("%s count step %0d", nm, k), int'(count), c);
      check($sformatf("%s done step %0d", nm, k), int'(done), (k == n) ? oh : 0);
    end
    tick;
    check($sformatf("%s end gnt", nm), int'(gnt), 0);
    check($sformatf("%s end busy", nm), int'(busy), 0);
    check($sformatf("%s end done", nm), int'(done), 0);
    check($sformatf("%s end count", nm), int'(count), e);
  endtask

  initial begin
    //             rst   req    s0    e0    s1    e1    gnt    done   bsy   cnt   dir
    tbl[0]  = '{1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd3, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd4, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd5, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd6, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 4'd3, 4'd7, 4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 4'd7, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 4'd3, 4'd7, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'd7, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 4'd9, 4'd9, 4'd0, 4'd0, 2'b01, 2'b00, 1'b1, 4'd7, 1'b0};
    tbl[9]  = '{1'b0, 2'b01, 4'd9, 4'd9, 4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 4'd9, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 4'd9, 4'd9, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'd9, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 4'd9, 4'd9, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'd9, 1'b0};

    rst = 1'b1; req = 2'b00;
    start0 = 4'd0; stop0 = 4'd0; start1 = 4'd0; stop1 = 4'd0;
    tick;
    tick;

    // Reset state, single up ramp 3->7, zero-length ramp at 9
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; req = tbl[i].req;
      start0 = tbl[i].s0; stop0 = tbl[i].e0;
      start1 = tbl[i].s1; stop1 = tbl[i].e1;
      tick;
      check($sformatf("vec%0d gnt", i),   int'(gnt),   int'(tbl[i].gnt));
      check($sformatf("vec%0d done", i),  int'(done),  int'(tbl[i].done));
      check($sformatf("vec%0d busy", i),  int'(busy),  int'(tbl[i].busy));
      check($sformatf("vec%0d count", i), int'(count), int'(tbl[i].count));
      check($sformatf("vec%0d dir", i),   int'(dir),   int'(tbl[i].dir));
    end

    // Down ramp 15->0 on requester 1: no wrap, done 17 cycles after request
    start1 = 4'd15; stop1 = 4'd0; req = 2'b10;
    ramp(1, 15, 0, "down");
    req = 2'b00;
    tick;

    // Round-robin with both requests held: 0, 1, 0
    start0 = 4'd1; stop0 = 4'd2; start1 = 4'd5; stop1 = 4'd3; req = 2'b11;
    ramp(0, 1, 2, "rr0");
    ramp(1, 5, 3, "rr1");
    ramp(0, 1, 2, "rr2");
    req = 2'b00;
    tick;

    // Abort: ramp 2->10 dropped at count 5, pending requester 1 served next
    start0 = 4'd2; stop0 = 4'd10; start1 = 4'd4; stop1 = 4'd6; req = 2'b01;
    tick;
    check("abort load gnt", int'(gnt), 1);
    req = 2'b11;
    stop0 = 4'd3;  // endpoints already captured; must not affect this ramp
    tick;
    check("abort count2", int'(count), 2);
    tick;
    check("abort count3", int'(count), 3);
    tick;
    check("abort count4", int'(count), 4);
    tick;
    check("abort count5", int'(count), 5);
    check("abort no early done", int'(done), 0);
    req = 2'b10;
    tick;
    check("abort gnt", int'(gnt), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort count hold", int'(count), 5);
    ramp(1, 4, 6, "after abort");
    req = 2'b00;
    tick;

    // Reset in the middle of a ramp, then confirm pointer returns to favour 0
    start0 = 4'd0; stop0 = 4'd15; req = 2'b01;
    tick;
    tick;
    tick;
    tick;
    check("pre-reset count", int'(count), 2);
    rst = 1'b1;
    tick;
    check("rst count", int'(count), 0);
    check("rst gnt", int'(gnt), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst dir", int'(dir), 0);
    rst = 1'b0; req = 2'b00;
    tick;
    check("post-rst idle busy", int'(busy), 0);
    start0 = 4'd6; stop0 = 4'd4; start1 = 4'd8; stop1 = 4'd9; req = 2'b11;
    ramp(0, 6, 4, "post-rst tie");
    req = 2'b00;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
